// File: rtl/fir_pkg.sv
// Shared helpers and types for the polyphase interpolating FIR.
package fir_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int sum_width(input int prod_w, input int taps);
    return prod_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_interp_phase_mac.sv
// Per-phase multiply-accumulate: coefficient mux by phase, registered products, adder tree.
// Products land one clock after issue; everything holds while en is low.
module fir_interp_phase_mac
  import fir_pkg::*;
#(
  parameter int INPUT_WIDTH = 16,
  parameter int COEFF_WIDTH = 8,
  parameter int INTERP      = 4,
  parameter int NUM_TAPS    = 32,
  parameter logic signed [COEFF_WIDTH-1:0] COEFFS [0:NUM_TAPS-1] = '{default: '0}
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en,
  input  logic                                   issue,
  input  logic [$clog2(INTERP)-1:0]              phase,
  input  logic [ceil_div(NUM_TAPS, INTERP)*INPUT_WIDTH-1:0] taps,
  output logic [$clog2(INTERP)-1:0]              phase1,
  output logic                                   v1,
  output logic signed [sum_width(INPUT_WIDTH+COEFF_WIDTH, ceil_div(NUM_TAPS, INTERP))-1:0] sum
);

  localparam int TPP    = ceil_div(NUM_TAPS, INTERP);
  localparam int PROD_W = INPUT_WIDTH + COEFF_WIDTH;
  localparam int SUM_W  = sum_width(PROD_W, TPP);

  logic signed [COEFF_WIDTH-1:0] tbl [TPP][INTERP];
  logic signed [COEFF_WIDTH-1:0] cs [TPP];
  logic signed [INPUT_WIDTH-1:0] xs [TPP];
  logic signed [PROD_W-1:0]      prod_r [TPP];

  // Taps past the end of the prototype are zero so every branch has TPP taps.
  for (genvar k = 0; k < TPP; k++) begin : g_tap
    for (genvar p = 0; p < INTERP; p++) begin : g_ph
      if (k*INTERP + p < NUM_TAPS) begin : g_coef
        assign tbl[k][p] = COEFFS[k*INTERP + p];
      end else begin : g_zero
        assign tbl[k][p] = '0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < TPP; i++) begin
      xs[i] = $signed(taps[i*INPUT_WIDTH +: INPUT_WIDTH]);
      cs[i] = tbl[i][phase];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TPP; i++) prod_r[i] <= '0;
      phase1 <= '0;
      v1     <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < TPP; i++) prod_r[i] <= PROD_W'(xs[i]) * PROD_W'(cs[i]);
      phase1 <= phase;
      v1     <= issue;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < TPP; i++) sum = sum + SUM_W'(prod_r[i]);
  end

endmodule

// File: rtl/fir_interp_polyphase.sv
// Polyphase interpolator: INTERP outputs per accepted sample, first output 2 clocks after accept.
// Optional FIR_INTERP_ROUND_EN selects round-half-up with saturation instead of truncation.
module fir_interp_polyphase
  import fir_pkg::*;
#(
  parameter int INPUT_WIDTH       = 16,
  parameter int COEFF_WIDTH       = 8,
  parameter int OUTPUT_WIDTH      = 26,
  parameter int OUTPUT_WIDTH_FULL = 26,
  parameter int INTERP            = 4,
  parameter int NUM_TAPS          = 32,
  parameter logic signed [COEFF_WIDTH-1:0] COEFFS [0:NUM_TAPS-1] = '{
    8'sd1,  8'sd2,  8'sd3,  8'sd5,  8'sd7,  8'sd10, 8'sd13, 8'sd17,
    8'sd21, 8'sd25, 8'sd29, 8'sd33, 8'sd36, 8'sd39, 8'sd41, 8'sd42,
    8'sd42, 8'sd41, 8'sd39, 8'sd36, 8'sd33, 8'sd29, 8'sd25, 8'sd21,
    8'sd17, 8'sd13, 8'sd10, 8'sd7,  8'sd5,  8'sd3,  8'sd2,  8'sd1}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_in,
  output logic                           ready_in,
  input  logic signed [INPUT_WIDTH-1:0]  din,
  output logic                           valid_out,
  input  logic                           ready_out,
  output logic signed [OUTPUT_WIDTH-1:0] dout,
  output logic [$clog2(INTERP)-1:0]      phase_out
);

  localparam int PW    = $clog2(INTERP);
  localparam int TPP   = ceil_div(NUM_TAPS, INTERP);
  localparam int TW    = TPP * INPUT_WIDTH;
  localparam int SUM_W = sum_width(INPUT_WIDTH + COEFF_WIDTH, TPP);
  localparam int OWF   = OUTPUT_WIDTH_FULL;
  localparam int OW    = OUTPUT_WIDTH;
  localparam logic [PW-1:0] LAST = PW'(INTERP - 1);

  state_t                   state, state_nxt;
  logic [PW-1:0]            phase, phase_nxt, phase1;
  logic [TW-1:0]            taps;
  logic                     en, accept, issue, v1;
  logic signed [SUM_W-1:0]  sum;
  logic signed [OWF-1:0]    full;
  logic signed [OW-1:0]     conv;

  assign en       = ~valid_out | ready_out;
  assign ready_in = rst_n & en & ((state == IDLE) | (state == RUN & phase == LAST));
  assign accept   = valid_in & ready_in;
  assign issue    = (state == RUN) & en;

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      IDLE: if (accept) begin
        state_nxt = RUN;
        phase_nxt = '0;
      end
      RUN: if (en) begin
        if (phase == LAST) begin
          phase_nxt = '0;
          if (!accept) state_nxt = IDLE;
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Newest sample occupies the low slice of the delay line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
      taps  <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      if (accept) taps <= (taps << INPUT_WIDTH) | TW'($unsigned(din));
    end
  end

  fir_interp_phase_mac #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .INTERP      (INTERP),
    .NUM_TAPS    (NUM_TAPS),
    .COEFFS      (COEFFS)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .issue  (issue),
    .phase  (phase),
    .taps   (taps),
    .phase1 (phase1),
    .v1     (v1),
    .sum    (sum)
  );

  if (OWF >= SUM_W) begin : g_full_ext
    assign full = OWF'(sum);
  end else begin : g_full_trunc
    logic [SUM_W-OWF-1:0] unused_msbs;
    assign full        = sum[OWF-1:0];
    assign unused_msbs = sum[SUM_W-1:OWF];
  end

  if (OW > OWF) begin : g_out_ext
    assign conv = OW'(full);
  end else if (OW == OWF) begin : g_out_same
    assign conv = full;
  end else begin : g_out_narrow
    localparam int DROP = OWF - OW;
`ifdef FIR_INTERP_ROUND_EN
    localparam logic [OWF:0] HALF = {{OWF{1'b0}}, 1'b1} << (DROP - 1);
    logic [OWF:0]     rnd;
    logic [OW:0]      cand;
    logic [DROP-1:0]  unused_lsbs;
    assign rnd         = {full[OWF-1], full} + HALF;
    assign cand        = rnd[OWF:DROP];
    assign unused_lsbs = rnd[DROP-1:0];
    // Adding a positive half can only overflow upward, so clamp to max positive.
    assign conv = (cand[OW] != cand[OW-1]) ? {1'b0, {(OW-1){1'b1}}} : cand[OW-1:0];
`else
    logic [DROP-1:0] unused_lsbs;
    assign conv        = full[OWF-1:DROP];
    assign unused_lsbs = full[DROP-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      dout      <= '0;
      phase_out <= '0;
    end else if (en) begin
      valid_out <= v1;
      if (v1) begin
        dout      <= conv;
        phase_out <= phase1;
      end
    end
  end

endmodule

// File: tb/tb_fir_interp_polyphase.sv
// Scoreboard bench: full-width instance plus a 24-bit output instance sharing stimulus.
module tb_fir_interp_polyphase;

  localparam int IW = 16;
  localparam int CW = 8;
  localparam int INTERP = 4;
  localparam int NT = 8;
  localparam logic signed [CW-1:0] TB_COEFFS [0:NT-1] =
    '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd4, 8'sd3, 8'sd2, 8'sd1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out = 1'b1;
  logic [15:0] din = '0;
  logic        ready_in_a, valid_out_a, ready_in_b, valid_out_b;
  logic [25:0] dout_a;
  logic [23:0] dout_b;
  logic [1:0]  phase_out_a, phase_out_b;

  always #5 clk = ~clk;

  fir_interp_polyphase #(.INPUT_WIDTH(IW), .COEFF_WIDTH(CW), .OUTPUT_WIDTH(26),
    .OUTPUT_WIDTH_FULL(26), .INTERP(INTERP), .NUM_TAPS(NT), .COEFFS(TB_COEFFS)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in_a), .din(din),
    .valid_out(valid_out_a), .ready_out(ready_out), .dout(dout_a), .phase_out(phase_out_a));

  fir_interp_polyphase #(.INPUT_WIDTH(IW), .COEFF_WIDTH(CW), .OUTPUT_WIDTH(24),
    .OUTPUT_WIDTH_FULL(26), .INTERP(INTERP), .NUM_TAPS(NT), .COEFFS(TB_COEFFS)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in_b), .din(din),
    .valid_out(valid_out_b), .ready_out(ready_out), .dout(dout_b), .phase_out(phase_out_b));

  typedef struct { int ph; int full; } exp_t;
  typedef struct {
    int cyc; int ph_a; int ph_b; int dout_a; int dout_b; bit vb;
    int exp_ph; int exp_full; bit missing;
  } got_t;

  exp_t exp_q[$];
  got_t got_q[$];
  int   xm[2];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  function automatic int h(input int i);
    return (i < NT) ? int'(TB_COEFFS[i]) : 0;
  endfunction

  function automatic int conv_b(input int full);
    int r;
`ifdef FIR_INTERP_ROUND_EN
    r = (full + 2) >>> 2;
    if (r > 8388607) r = 8388607;
`else
    r = full >>> 2;
`endif
    return r;
  endfunction

  // One clock: sample just after the falling edge, record handshakes, advance.
  task automatic tick(output bit acc);
    got_t g;
    exp_t e;
    #1;
    acc = valid_in & ready_in_a;
    if (valid_out_a & ready_out) begin
      g = '{default: 0};
      g.cyc = cyc; g.ph_a = int'(phase_out_a); g.ph_b = int'(phase_out_b);
      g.dout_a = int'($signed(dout_a)); g.dout_b = int'($signed(dout_b)); g.vb = valid_out_b;
      if (exp_q.size() == 0) g.missing = 1'b1;
      else begin e = exp_q.pop_front(); g.exp_ph = e.ph; g.exp_full = e.full; end
      got_q.push_back(g);
    end
    if (!rst_n) begin
      exp_q.delete();
      xm = '{0, 0};
    end else if (acc) begin
      xm[1] = xm[0];
      xm[0] = int'($signed(din));
      for (int p = 0; p < INTERP; p++) begin
        e.ph = p;
        e.full = h(p) * xm[0] + h(INTERP + p) * xm[1];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic feed(input int vals[$], output bit ok);
    bit acc;
    int n;
    ok = 1'b1;
    foreach (vals[i]) begin
      valid_in = 1'b1;
      din = 16'(vals[i]);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin tick(acc); n++; end
      if (!acc) ok = 1'b0;
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    bit a;
    int n = 0;
    while ((exp_q.size() != 0 || valid_out_a) && n < 200) begin tick(a); n++; end
    ok = (exp_q.size() == 0) && !valid_out_a;
  endtask

  task automatic test_reset();
    bit a;
    rst_n = 1'b0;
    @(negedge clk);
    tick(a); tick(a);
    #1;
    checks++;
    if (ready_in_a !== 1'b0) begin failures++; $display("FAIL reset_ready_low got=%b want=0", ready_in_a); end
    checks++;
    if (valid_out_a !== 1'b0 || valid_out_b !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b/%b want=0/0", valid_out_a, valid_out_b);
    end
    checks++;
    if (dout_a !== 26'd0 || dout_b !== 24'd0) begin
      failures++; $display("FAIL reset_dout got=%0h/%0h want=0/0", dout_a, dout_b);
    end
    checks++;
    if (phase_out_a !== 2'd0) begin failures++; $display("FAIL reset_phase got=%0d want=0", phase_out_a); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready_in_a !== 1'b1) begin failures++; $display("FAIL reset_ready_idle got=%b want=1", ready_in_a); end
  endtask

  task automatic test_impulse();
    int tab[12] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0, 0, 0};
    int c0, idx;
    bit ok;
    got_t g;
    c0 = cyc;
    feed('{1, 0, 0}, ok);
    wait_idle(ok);
    checks++;
    if (!ok || got_q.size() != 12) begin failures++; $display("FAIL impulse_count got=%0d want=12", got_q.size()); end
    checks++;
    if (got_q.size() == 0 || got_q[0].cyc != c0 + 3) begin
      failures++; $display("FAIL impulse_latency got=%0d want=%0d", (got_q.size() != 0) ? got_q[0].cyc - c0 : -1, 3);
    end
    idx = 0;
    while (got_q.size() != 0) begin
      g = got_q.pop_front();
      checks++;
      if (g.missing || g.ph_a !== g.exp_ph || g.dout_a !== g.exp_full || !g.vb || g.ph_b !== g.exp_ph || g.dout_b !== conv_b(g.exp_full)) begin
        failures++; $display("FAIL impulse_model idx=%0d got ph=%0d a=%0d b=%0d want ph=%0d a=%0d b=%0d", idx, g.ph_a, g.dout_a, g.dout_b, g.exp_ph, g.exp_full, conv_b(g.exp_full));
      end
      checks++;
      if (idx < 12 && (g.dout_a !== tab[idx] || g.ph_a !== idx % 4)) begin
        failures++; $display("FAIL impulse_value idx=%0d got=%0d/ph%0d want=%0d/ph%0d", idx, g.dout_a, g.ph_a, tab[idx], idx % 4);
      end
      idx++;
    end
  endtask

  task automatic test_negative();
    int tab[8] = '{-1, -2, -3, -4, -4, -3, -2, -1};
    int idx;
    bit ok;
    got_t g;
    feed('{0, -1, 0}, ok);
    wait_idle(ok);
    checks++;
    if (!ok || got_q.size() != 12) begin failures++; $display("FAIL negative_count got=%0d want=12", got_q.size()); end
    idx = 0;
    while (got_q.size() != 0) begin
      g = got_q.pop_front();
      checks++;
      if (g.missing || g.ph_a !== g.exp_ph || g.dout_a !== g.exp_full || g.dout_b !== conv_b(g.exp_full)) begin
        failures++; $display("FAIL negative_model idx=%0d got a=%0d b=%0d want a=%0d b=%0d", idx, g.dout_a, g.dout_b, g.exp_full, conv_b(g.exp_full));
      end
      if (idx >= 4) begin
        checks++;
        if (g.dout_a !== tab[idx-4]) begin failures++; $display("FAIL negative_value idx=%0d got=%0d want=%0d", idx, g.dout_a, tab[idx-4]); end
      end
      idx++;
    end
  endtask

  task automatic test_back_to_back_dc();
    int idx, prev;
    bit ok;
    got_t g;
    feed('{100, 100, 100, 100, 100, 100}, ok);
    wait_idle(ok);
    checks++;
    if (!ok || got_q.size() != 24) begin failures++; $display("FAIL dc_count got=%0d want=24", got_q.size()); end
    idx = 0;
    prev = -10;
    while (got_q.size() != 0) begin
      g = got_q.pop_front();
      checks++;
      if (g.missing || g.dout_a !== g.exp_full || g.dout_b !== conv_b(g.exp_full)) begin
        failures++; $display("FAIL dc_model idx=%0d got=%0d want=%0d", idx, g.dout_a, g.exp_full);
      end
      if (idx >= 4) begin
        checks++;
        if (g.dout_a !== 500 || g.cyc != prev + 1) begin
          failures++; $display("FAIL dc_steady idx=%0d got=%0d gap=%0d want=500 gap=1", idx, g.dout_a, g.cyc - prev);
        end
      end
      prev = g.cyc;
      idx++;
    end
  endtask

  task automatic test_backpressure();
    int pend[$] = '{0, 1, 0};
    int stall = 0, hd = 0, hp = 0, idx = 0, t = 0;
    bit done = 1'b0, acc, ok;
    got_t g;
    while (t < 80 && (pend.size() != 0 || exp_q.size() != 0 || valid_out_a)) begin
      valid_in = (pend.size() != 0);
      din = (pend.size() != 0) ? 16'(pend[0]) : 16'd0;
      if (!done && valid_out_a && phase_out_a == 2'd2) begin
        ready_out = 1'b0; stall = 3; done = 1'b1;
        hd = int'($signed(dout_a)); hp = int'(phase_out_a);
      end
      if (stall > 0) begin
        #1;
        checks++;
        if (ready_in_a !== 1'b0) begin failures++; $display("FAIL bp_ready_in got=%b want=0", ready_in_a); end
      end
      tick(acc);
      if (acc) void'(pend.pop_front());
      if (stall > 0) begin
        stall--;
        checks++;
        if (!valid_out_a || int'($signed(dout_a)) != hd || int'(phase_out_a) != hp) begin
          failures++; $display("FAIL bp_hold got v=%b d=%0d ph=%0d want v=1 d=%0d ph=%0d", valid_out_a, $signed(dout_a), phase_out_a, hd, hp);
        end
        if (stall == 0) ready_out = 1'b1;
      end
      t++;
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok || !done || got_q.size() != 12) begin failures++; $display("FAIL bp_count got=%0d want=12", got_q.size()); end
    while (got_q.size() != 0) begin
      g = got_q.pop_front();
      checks++;
      if (g.missing || g.ph_a !== g.exp_ph || g.dout_a !== g.exp_full || g.dout_b !== conv_b(g.exp_full)) begin
        failures++; $display("FAIL bp_model idx=%0d got ph=%0d a=%0d want ph=%0d a=%0d", idx, g.ph_a, g.dout_a, g.exp_ph, g.exp_full);
      end
      idx++;
    end
  endtask

  task automatic test_midburst_reset();
    int tab[8] = '{1, 2, 3, 4, 4, 3, 2, 1};
    int t = 0, idx = 0;
    bit acc, ok, hit = 1'b0;
    got_t g;
    valid_in = 1'b1;
    din = 16'd1;
    while (t < 40 && !hit) begin
      if (valid_out_a && phase_out_a == 2'd1) begin
        rst_n = 1'b0;
        tick(acc);
        rst_n = 1'b1;
        hit = 1'b1;
      end else begin
        tick(acc);
        if (acc) din = 16'd0;
      end
      t++;
    end
    valid_in = 1'b0;
    #1;
    checks++;
    if (!hit || valid_out_a !== 1'b0 || dout_a !== 26'd0 || phase_out_a !== 2'd0) begin
      failures++; $display("FAIL midreset_out got v=%b d=%0d ph=%0d want v=0 d=0 ph=0", valid_out_a, dout_a, phase_out_a);
    end
    checks++;
    if (valid_out_b !== 1'b0 || dout_b !== 24'd0) begin failures++; $display("FAIL midreset_out_b got v=%b d=%0d want 0/0", valid_out_b, dout_b); end
    while (got_q.size() != 0) begin
      g = got_q.pop_front();
      checks++;
      if (g.missing || g.dout_a !== g.exp_full) begin failures++; $display("FAIL midreset_pre got=%0d want=%0d", g.dout_a, g.exp_full); end
    end
    feed('{1, 0}, ok);
    wait_idle(ok);
    checks++;
    if (!ok || got_q.size() != 8) begin failures++; $display("FAIL midreset_count got=%0d want=8", got_q.size()); end
    while (got_q.size() != 0) begin
      g = got_q.pop_front();
      checks++;
      if (idx < 8 && (g.dout_a !== tab[idx] || g.ph_a !== idx % 4)) begin
        failures++; $display("FAIL midreset_value idx=%0d got=%0d want=%0d", idx, g.dout_a, tab[idx]);
      end
      idx++;
    end
  endtask

  task automatic test_round();
    int idx = 0, want2;
    bit ok;
    got_t g;
`ifdef FIR_INTERP_ROUND_EN
    want2 = 2;
`else
    want2 = 1;
`endif
    feed('{2, 0}, ok);
    wait_idle(ok);
    checks++;
    if (!ok || got_q.size() != 8) begin failures++; $display("FAIL round_count got=%0d want=8", got_q.size()); end
    while (got_q.size() != 0) begin
      g = got_q.pop_front();
      checks++;
      if (g.missing || g.dout_b !== conv_b(g.exp_full) || g.ph_b !== g.exp_ph) begin
        failures++; $display("FAIL round_model idx=%0d got=%0d want=%0d", idx, g.dout_b, conv_b(g.exp_full));
      end
      if (idx == 2) begin
        checks++;
        if (g.dout_a !== 6 || g.dout_b !== want2) begin
          failures++; $display("FAIL round_six got full=%0d out=%0d want full=6 out=%0d", g.dout_a, g.dout_b, want2);
        end
      end
      idx++;
    end
  endtask

  initial begin
    xm = '{0, 0};
    test_reset();
    test_impulse();
    test_negative();
    test_back_to_back_dc();
    test_backpressure();
    test_midburst_reset();
    test_round();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_interp_polyphase.md
# fir_interp_polyphase

Polyphase interpolating FIR filter: accepts one input sample at a time and produces `INTERP` filtered output samples per input, one per clock, through a valid/ready handshake. It sits on the output side of the datapath, upsampling toward the DAC. It is the counterpart of the systolic decimation-side filters. Input and output both have backpressure because output rate exceeds input rate.

## Interface
- `INPUT_WIDTH`, 16: signed input sample width
- `COEFF_WIDTH`, 8: signed coefficient width
- `OUTPUT_WIDTH`, 26: output width after truncation or rounding
- `OUTPUT_WIDTH_FULL`, 26: full-precision width taken from the sum
- `INTERP`, 4: interpolation factor, at least 2
- `NUM_TAPS`, 32: prototype filter length
- `COEFFS`, `'{...}`: `[0:NUM_TAPS-1]` signed prototype coefficients
- `clk`, input, 1: clock
- `rst_n`, input, 1: reset. One clock; reset is synchronous and active-low.
- `valid_in`, input, 1: `din` valid
- `ready_in`, output, 1: block accepts `din` this cycle
- `din`, input, `INPUT_WIDTH`: signed input sample
- `valid_out`, output, 1: `dout` valid
- `ready_out`, input, 1: downstream accepts `dout`
- `dout`, output, `OUTPUT_WIDTH`: signed output sample
- `phase_out`, output, `$clog2(INTERP)`: polyphase index of `dout`

## Operation
- `TPP = ceil(NUM_TAPS/INTERP)`. Coefficient `h[k*INTERP+p]` for index ≥ `NUM_TAPS` is 0.
- Delay line `x[0..TPP-1]` shifts on accept (`valid_in & ready_in`), with `x[0]` = `din`.
- Output for phase p is `Σk h[k*INTERP+p]*x[k]`.
- FSM states:
  - IDLE → RUN on accept; phase=0.
  - RUN issues phase p per enabled cycle.
  - At p=INTERP-1: if a new accept happens in the same cycle → RUN with phase=0 (no bubble); else → IDLE.
- `ready_in` = 0 while `rst_n`=0. Otherwise `ready_in` = (IDLE | (RUN & phase==INTERP-1)) & `en`.
- Pipeline, global enable `en = ~valid_out | ready_out`:
  - stage 1 registers `TPP` products plus `phase` plus `v1`;
  - stage 2 registers the sum, `phase_out` and `valid_out`.
  - When `en`=0, all state holds: delay line, phase, FSM, both stages.
- Arithmetic:
  - product width is `INPUT_WIDTH+COEFF_WIDTH`, signed;
  - sum width is product width + `$clog2(TPP)`;
  - the sum is sign-extended or truncated to `OUTPUT_WIDTH_FULL`.
  - If `OUTPUT_WIDTH ≤ OUTPUT_WIDTH_FULL`, keep the top `OUTPUT_WIDTH` bits; else sign-extend.
- No flush. The last sample's `INTERP` outputs drain, then the block idles.
- Reset (any time, including mid-burst):
  - next cycle `valid_out`=0, `dout`=0, `phase_out`=0;
  - delay line, products and `v1` are cleared; FSM goes to IDLE.
  - Pending phases are discarded.

## Timing
- With `ready_out`=1 throughout, a sample accepted at edge k produces phase p on `dout` registered at edge k+2+p.
- Sustained throughput: 1 output per clock with one input every `INTERP` clocks.
- A stall (`valid_out & ~ready_out`) freezes `dout`/`phase_out`/`valid_out` unchanged until accepted. No output is lost or duplicated.
- `ready_in` is combinational from state and `ready_out`. `valid_out` and `dout` are registered.

## Configuration
- `FIR_INTERP_ROUND_EN` defined: when `OUTPUT_WIDTH < OUTPUT_WIDTH_FULL`, the block adds `1<<(OUTPUT_WIDTH_FULL-OUTPUT_WIDTH-1)` before dropping LSBs (round half up). The result saturates at the maximum positive value on overflow.
- Undefined: plain LSB truncation.
- No effect when `OUTPUT_WIDTH ≥ OUTPUT_WIDTH_FULL`.

## Structure
- Shared package `fir_pkg`:
  - `ceil_div` function;
  - sum-width helper function;
  - FSM state typedef (IDLE, RUN).
- One sub-module, `fir_interp_phase_mac`:
  - `TPP` multipliers with coefficient mux by phase, stage-1 product registers, and the adder;
  - inputs are the delay line and phase; enable comes from the parent.
- The top holds the delay line, FSM, phase counter, handshake, and output register with rounding.

## Test plan
Common setup: `INTERP`=4, `NUM_TAPS`=8, `COEFFS`={1,2,3,4,4,3,2,1}, widths equal, `ready_out`=1 unless stated.
- Impulse: `din`=1, then 0 → `dout` 1,2,3,4,4,3,2,1, then 0; `phase_out` 0,1,2,3 repeating; first output at edge k+2.
- DC: `din`=100 every 4 clocks → steady `dout`=500 on every clock, `valid_out` continuous, no bubbles.
- Negative impulse: `din`=-1 → `dout` -1,-2,-3,-4,-4,-3,-2,-1.
- Backpressure: drop `ready_out` for 3 clocks during phase 2 → `dout`/`phase_out` held, `ready_in`=0; the full sequence completes without loss or duplication.
- Mid-burst reset: `rst_n`=0 for 1 clock at phase 1 → next cycle `valid_out`=0, `dout`=0; a repeated impulse afterwards gives a clean 1,2,3,4,4,3,2,1.
- Rounding: `OUTPUT_WIDTH_FULL`=26, `OUTPUT_WIDTH`=24, full sum 6 → `dout`=2 with `FIR_INTERP_ROUND_EN`, 1 without.
